// File: rtl/memory_access_stage_v2_if.sv
// Bundle of the Execute -> MEM stage inputs and the MEM/WB register outputs.
// The master side belongs to the pipeline driving the stage; the slave side is
// the MEM stage itself.
interface memory_access_stage_v2_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  enableWriteRegisterFile_Execute;
    logic [4:0]            addressWriteRegisterFile_Execute;
    logic                  controlSignalWriteFromDataMemoryRegisterFile_Execute;
    logic [DATA_WIDTH-1:0] resultALU_Execute;
    logic                  enableReadDataMemory_Execute;
    logic                  enableWriteDataMemory_Execute;
    logic [1:0]            accessSize_Execute;
    logic                  loadUnsigned_Execute;
    logic [DATA_WIDTH-1:0] dataToWriteDataMemory_Execute;
    logic [31:0]           instruction_Execute;
    logic                  controlSignalFowardDataReadDataMemory_FowardingUnit;
    logic [DATA_WIDTH-1:0] fowardDataToWriteDataMemory_FowardingUnit;

    logic [DATA_WIDTH-1:0] dataReadDataMemory_MemoryAccess;
    logic [DATA_WIDTH-1:0] resultALU_MemoryAccess;
    logic                  controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess;
    logic                  enableWriteRegisterFile_MemoryAccess;
    logic [4:0]            addressWriteRegisterFile_MemoryAccess;
    logic                  enableReadDataMemory_MemoryAccess;
    logic [31:0]           instruction_MemoryAccess;
    logic                  stall_MemoryAccess;
    logic                  misalignedException_MemoryAccess;

    modport master (
        output enableWriteRegisterFile_Execute,
        output addressWriteRegisterFile_Execute,
        output controlSignalWriteFromDataMemoryRegisterFile_Execute,
        output resultALU_Execute,
        output enableReadDataMemory_Execute,
        output enableWriteDataMemory_Execute,
        output accessSize_Execute,
        output loadUnsigned_Execute,
        output dataToWriteDataMemory_Execute,
        output instruction_Execute,
        output controlSignalFowardDataReadDataMemory_FowardingUnit,
        output fowardDataToWriteDataMemory_FowardingUnit,
        input  dataReadDataMemory_MemoryAccess,
        input  resultALU_MemoryAccess,
        input  controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess,
        input  enableWriteRegisterFile_MemoryAccess,
        input  addressWriteRegisterFile_MemoryAccess,
        input  enableReadDataMemory_MemoryAccess,
        input  instruction_MemoryAccess,
        input  stall_MemoryAccess,
        input  misalignedException_MemoryAccess
    );

    modport slave (
        input  enableWriteRegisterFile_Execute,
        input  addressWriteRegisterFile_Execute,
        input  controlSignalWriteFromDataMemoryRegisterFile_Execute,
        input  resultALU_Execute,
        input  enableReadDataMemory_Execute,
        input  enableWriteDataMemory_Execute,
        input  accessSize_Execute,
        input  loadUnsigned_Execute,
        input  dataToWriteDataMemory_Execute,
        input  instruction_Execute,
        input  controlSignalFowardDataReadDataMemory_FowardingUnit,
        input  fowardDataToWriteDataMemory_FowardingUnit,
        output dataReadDataMemory_MemoryAccess,
        output resultALU_MemoryAccess,
        output controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess,
        output enableWriteRegisterFile_MemoryAccess,
        output addressWriteRegisterFile_MemoryAccess,
        output enableReadDataMemory_MemoryAccess,
        output instruction_MemoryAccess,
        output stall_MemoryAccess,
        output misalignedException_MemoryAccess
    );
endinterface

// File: rtl/memory_access_stage_v2.sv
// MEM stage of the MIPS pipeline: data memory with byte/half/word/dword
// accesses, sign/zero extension, wait-state stall FSM, store-data forwarding
// and the MEM/WB pipeline register.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN. When defined, misaligned
// or illegal-size accesses are suppressed and flagged; otherwise the address
// is aligned down and the access proceeds.
module memory_access_stage_v2 #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   resetMachine_n,
    memory_access_stage_v2_if.slave bus
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_BITS = $clog2(MEM_DEPTH);
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [2:0] WAIT_LOAD = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    logic [DATA_WIDTH-1:0] memArray [MEM_DEPTH];

    state_t                state_q, state_d;
    logic [2:0]            count_q, count_d;
    logic                  stall;

    logic [DATA_WIDTH-1:0] dataRead_q;
    logic [DATA_WIDTH-1:0] resultAlu_q;
    logic                  memToReg_q;
    logic                  regWrite_q;
    logic [4:0]            regAddr_q;
    logic                  memRead_q;
    logic [31:0]           instruction_q;
    logic                  misaligned_q;

    logic                  access;
    logic                  readOnly;
    logic                  signExt;
    logic [IDX_BITS-1:0]   memIndex;
    logic [OFF_BITS-1:0]   rawOffset;
    logic [OFF_BITS-1:0]   alignedOffset;
    logic                  misaligned;
    logic                  trapActive;
    logic                  commitWrite;
    logic [DATA_WIDTH-1:0] storeData;
    logic [DATA_WIDTH-1:0] writeData;
    logic [BYTES-1:0]      byteEnable;
    logic [DATA_WIDTH-1:0] memWord;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] wordExt;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] readResult;
    logic                  unusedAddrBits;

    assign access      = bus.enableReadDataMemory_Execute | bus.enableWriteDataMemory_Execute;
    assign readOnly    = bus.enableReadDataMemory_Execute & ~bus.enableWriteDataMemory_Execute;
    assign signExt     = ~bus.loadUnsigned_Execute;
    assign memIndex    = bus.resultALU_Execute[OFF_BITS +: IDX_BITS];
    assign rawOffset   = bus.resultALU_Execute[OFF_BITS-1:0];
    assign unusedAddrBits = ^bus.resultALU_Execute;
    assign storeData   = bus.controlSignalFowardDataReadDataMemory_FowardingUnit
                       ? bus.fowardDataToWriteDataMemory_FowardingUnit
                       : bus.dataToWriteDataMemory_Execute;
    assign trapActive  = TRAP_EN & access & misaligned;
    assign commitWrite = bus.enableWriteDataMemory_Execute & ~stall & ~trapActive;

    // Alignment check and aligned-down lane offset for the requested size
    always_comb begin
        misaligned    = 1'b0;
        alignedOffset = rawOffset;
        case (bus.accessSize_Execute)
            2'b00: begin
                misaligned = 1'b0;
            end
            2'b01: begin
                misaligned       = rawOffset[0];
                alignedOffset[0] = 1'b0;
            end
            2'b10: begin
                misaligned         = |rawOffset[1:0];
                alignedOffset[1:0] = 2'b00;
            end
            default: begin
                misaligned    = (DATA_WIDTH == 32) ? 1'b1 : (|rawOffset);
                alignedOffset = '0;
            end
        endcase
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        byteEnable = '0;
        writeData  = storeData;
        case (bus.accessSize_Execute)
            2'b00: begin
                byteEnable = BYTES'(4'b0001) << alignedOffset;
                writeData  = {BYTES{storeData[7:0]}};
            end
            2'b01: begin
                byteEnable = BYTES'(4'b0011) << alignedOffset;
                writeData  = {(BYTES/2){storeData[15:0]}};
            end
            2'b10: begin
                byteEnable = BYTES'(4'b1111) << alignedOffset;
                writeData  = {(BYTES/4){storeData[31:0]}};
            end
            default: begin
                byteEnable = '1;
                writeData  = storeData;
            end
        endcase
    end

    assign memWord = memArray[memIndex];
    assign shifted = memWord >> {alignedOffset, 3'b000};

    generate
        if (DATA_WIDTH == 64) begin : gWideWord
            assign wordExt = {{(DATA_WIDTH-32){signExt & shifted[31]}}, shifted[31:0]};
        end else begin : gNarrowWord
            assign wordExt = shifted;
        end
    endgenerate

    // Lane extraction with sign or zero extension
    always_comb begin
        loadData = '0;
        case (bus.accessSize_Execute)
            2'b00:   loadData = {{(DATA_WIDTH-8){signExt & shifted[7]}}, shifted[7:0]};
            2'b01:   loadData = {{(DATA_WIDTH-16){signExt & shifted[15]}}, shifted[15:0]};
            2'b10:   loadData = wordExt;
            default: loadData = (DATA_WIDTH == 64) ? shifted : wordExt;
        endcase
    end

    assign readResult = (readOnly && !trapActive) ? loadData : '0;

    // Data memory write port; only at commit and never while reset is held
    always_ff @(posedge clock) begin
        if (resetMachine_n && commitWrite) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteEnable[b]) begin
                    memArray[memIndex][b*8 +: 8] <= writeData[b*8 +: 8];
                end
            end
        end
    end

    // Wait-state FSM register
    always_ff @(posedge clock or negedge resetMachine_n) begin
        if (!resetMachine_n) begin
            state_q <= ST_IDLE;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Wait-state FSM next state and stall decode
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && HAS_WAIT) begin
                    stall   = 1'b1;
                    count_d = WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_q != 3'd0) begin
                    stall   = 1'b1;
                    count_d = count_q - 3'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // MEM/WB pipeline register; bubbles are loaded while stalled
    always_ff @(posedge clock or negedge resetMachine_n) begin
        if (!resetMachine_n) begin
            dataRead_q    <= '0;
            resultAlu_q   <= '0;
            memToReg_q    <= 1'b0;
            regWrite_q    <= 1'b0;
            regAddr_q     <= 5'd0;
            memRead_q     <= 1'b0;
            instruction_q <= 32'd0;
            misaligned_q  <= 1'b0;
        end else if (stall) begin
            dataRead_q    <= '0;
            resultAlu_q   <= '0;
            memToReg_q    <= 1'b0;
            regWrite_q    <= 1'b0;
            regAddr_q     <= 5'd0;
            memRead_q     <= 1'b0;
            instruction_q <= 32'd0;
            misaligned_q  <= 1'b0;
        end else begin
            dataRead_q    <= readResult;
            resultAlu_q   <= bus.resultALU_Execute;
            memToReg_q    <= bus.controlSignalWriteFromDataMemoryRegisterFile_Execute;
            regWrite_q    <= bus.enableWriteRegisterFile_Execute & ~trapActive;
            regAddr_q     <= bus.addressWriteRegisterFile_Execute;
            memRead_q     <= bus.enableReadDataMemory_Execute;
            instruction_q <= bus.instruction_Execute;
            misaligned_q  <= trapActive;
        end
    end

    assign bus.dataReadDataMemory_MemoryAccess                          = dataRead_q;
    assign bus.resultALU_MemoryAccess                                   = resultAlu_q;
    assign bus.controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess = memToReg_q;
    assign bus.enableWriteRegisterFile_MemoryAccess                     = regWrite_q;
    assign bus.addressWriteRegisterFile_MemoryAccess                    = regAddr_q;
    assign bus.enableReadDataMemory_MemoryAccess                        = memRead_q;
    assign bus.instruction_MemoryAccess                                 = instruction_q;
    assign bus.stall_MemoryAccess                                       = stall;
    assign bus.misalignedException_MemoryAccess                         = misaligned_q;
endmodule

// File: tb/tb_memory_access_stage_v2.sv
// Scoreboard bench for memory_access_stage_v2: one instance with no wait
// states and one with three wait states, both at DATA_WIDTH=32.
module tb_memory_access_stage_v2;
    logic clock;
    logic resetMachine_n;
    int   checks;
    int   errors;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] data;
        logic        regWe;
        logic        memToReg;
        logic        readEn;
        logic [4:0]  regAddr;
        logic        checkData;
        logic        mis;
    } expect_t;

    expect_t q0[$];
    expect_t q3[$];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    memory_access_stage_v2_if #(.DATA_WIDTH(32)) bus0 ();
    memory_access_stage_v2_if #(.DATA_WIDTH(32)) bus3 ();

    memory_access_stage_v2 #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) uut0 (
        .clock(clock), .resetMachine_n(resetMachine_n), .bus(bus0));
    memory_access_stage_v2 #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) uut3 (
        .clock(clock), .resetMachine_n(resetMachine_n), .bus(bus3));

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveBus(input bit sel, input logic rd, input logic wr, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] data,
                            input logic fwdSel, input logic [31:0] fwdData, input logic regWe,
                            input logic [4:0] regAddr, input logic [31:0] tag);
        if (sel) begin
            bus3.enableReadDataMemory_Execute = rd;
            bus3.enableWriteDataMemory_Execute = wr;
            bus3.accessSize_Execute = size;
            bus3.loadUnsigned_Execute = uns;
            bus3.resultALU_Execute = addr;
            bus3.dataToWriteDataMemory_Execute = data;
            bus3.controlSignalFowardDataReadDataMemory_FowardingUnit = fwdSel;
            bus3.fowardDataToWriteDataMemory_FowardingUnit = fwdData;
            bus3.enableWriteRegisterFile_Execute = regWe;
            bus3.addressWriteRegisterFile_Execute = regAddr;
            bus3.controlSignalWriteFromDataMemoryRegisterFile_Execute = rd;
            bus3.instruction_Execute = tag;
        end else begin
            bus0.enableReadDataMemory_Execute = rd;
            bus0.enableWriteDataMemory_Execute = wr;
            bus0.accessSize_Execute = size;
            bus0.loadUnsigned_Execute = uns;
            bus0.resultALU_Execute = addr;
            bus0.dataToWriteDataMemory_Execute = data;
            bus0.controlSignalFowardDataReadDataMemory_FowardingUnit = fwdSel;
            bus0.fowardDataToWriteDataMemory_FowardingUnit = fwdData;
            bus0.enableWriteRegisterFile_Execute = regWe;
            bus0.addressWriteRegisterFile_Execute = regAddr;
            bus0.controlSignalWriteFromDataMemoryRegisterFile_Execute = rd;
            bus0.instruction_Execute = tag;
        end
    endtask

    task automatic driveIdle(input bit sel);
        driveBus(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Present one instruction, hold it through any stall, push its expected result
    task automatic applyStimulus(input bit sel, input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] data,
                                 input logic fwdSel, input logic [31:0] fwdData, input logic regWe,
                                 input logic [4:0] regAddr, input logic [31:0] tag,
                                 input logic [31:0] expData, input logic checkData, input logic expMis,
                                 output int stalls);
        expect_t e;
        bit      done;
        logic    st;
        e.instr = tag;      e.alu = addr;       e.data = expData;
        e.regWe = regWe & ~expMis;              e.memToReg = rd;
        e.readEn = rd;      e.regAddr = regAddr;
        e.checkData = checkData;                e.mis = expMis;
        if (sel) q3.push_back(e); else q0.push_back(e);
        driveBus(sel, rd, wr, size, uns, addr, data, fwdSel, fwdData, regWe, regAddr, tag);
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clock);
            if (sel && stalls > 0) begin
                checkOutput("bubble regWrite", 32'(bus3.enableWriteRegisterFile_MemoryAccess), 32'd0);
                checkOutput("bubble memRead", 32'(bus3.enableReadDataMemory_MemoryAccess), 32'd0);
                checkOutput("bubble instruction", bus3.instruction_MemoryAccess, 32'd0);
            end
            st = sel ? bus3.stall_MemoryAccess : bus0.stall_MemoryAccess;
            if (st == 1'b0) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall bound: tag 0x%08h still stalled, required release within 16 cycles", tag);
        end
        @(posedge clock);
        #1;
        checkOutput("commit tag", sel ? bus3.instruction_MemoryAccess : bus0.instruction_MemoryAccess, tag);
        if (!sel) checkOutput("ws0 stall cycles", 32'(stalls), 32'd0);
        driveIdle(sel);
    endtask

    task automatic doLoad(input bit sel, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [31:0] tag, input logic [31:0] expData, input logic expMis);
        int s;
        applyStimulus(sel, 1'b1, 1'b0, size, uns, addr, 32'd0, 1'b0, 32'd0, 1'b1, 5'd5, tag,
                      expData, 1'b1, expMis, s);
    endtask

    task automatic doStore(input bit sel, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] tag, input logic expMis);
        int s;
        applyStimulus(sel, 1'b0, 1'b1, size, 1'b0, addr, data, 1'b0, 32'd0, 1'b0, 5'd0, tag,
                      32'd0, 1'b0, expMis, s);
    endtask

    task automatic compareEntry(input string who, input expect_t e, input logic [31:0] instr,
                                input logic [31:0] alu, input logic [31:0] data, input logic regWe,
                                input logic memToReg, input logic readEn, input logic [4:0] regAddr,
                                input logic mis);
        checkOutput({who, " instruction"}, instr, e.instr);
        checkOutput({who, " resultALU"}, alu, e.alu);
        checkOutput({who, " regWrite"}, 32'(regWe), 32'(e.regWe));
        checkOutput({who, " memToReg"}, 32'(memToReg), 32'(e.memToReg));
        checkOutput({who, " memRead"}, 32'(readEn), 32'(e.readEn));
        checkOutput({who, " regAddr"}, 32'(regAddr), 32'(e.regAddr));
        checkOutput({who, " misaligned"}, 32'(mis), 32'(e.mis));
        if (e.checkData) checkOutput({who, " readData"}, data, e.data);
    endtask

    // Monitor for the zero-wait instance: every non-bubble output pops one entry
    always @(negedge clock) begin
        expect_t e;
        if (resetMachine_n && bus0.instruction_MemoryAccess != 32'd0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL ws0 unexpected output: tag 0x%08h, required none", bus0.instruction_MemoryAccess);
            end else begin
                e = q0.pop_front();
                compareEntry("ws0", e, bus0.instruction_MemoryAccess, bus0.resultALU_MemoryAccess,
                             bus0.dataReadDataMemory_MemoryAccess, bus0.enableWriteRegisterFile_MemoryAccess,
                             bus0.controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess,
                             bus0.enableReadDataMemory_MemoryAccess, bus0.addressWriteRegisterFile_MemoryAccess,
                             bus0.misalignedException_MemoryAccess);
            end
        end
    end

    // Monitor for the three-wait instance
    always @(negedge clock) begin
        expect_t e;
        if (resetMachine_n && bus3.instruction_MemoryAccess != 32'd0) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL ws3 unexpected output: tag 0x%08h, required none", bus3.instruction_MemoryAccess);
            end else begin
                e = q3.pop_front();
                compareEntry("ws3", e, bus3.instruction_MemoryAccess, bus3.resultALU_MemoryAccess,
                             bus3.dataReadDataMemory_MemoryAccess, bus3.enableWriteRegisterFile_MemoryAccess,
                             bus3.controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess,
                             bus3.enableReadDataMemory_MemoryAccess, bus3.addressWriteRegisterFile_MemoryAccess,
                             bus3.misalignedException_MemoryAccess);
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        int s;
        checks = 0;
        errors = 0;
        resetMachine_n = 1'b0;
        driveIdle(1'b0);
        driveIdle(1'b1);
        #12;
        checkOutput("reset readData", bus0.dataReadDataMemory_MemoryAccess, 32'd0);
        checkOutput("reset resultALU", bus0.resultALU_MemoryAccess, 32'd0);
        checkOutput("reset regWrite", 32'(bus0.enableWriteRegisterFile_MemoryAccess), 32'd0);
        checkOutput("reset instruction", bus0.instruction_MemoryAccess, 32'd0);
        checkOutput("reset stall", 32'(bus0.stall_MemoryAccess), 32'd0);
        checkOutput("reset misaligned", 32'(bus0.misalignedException_MemoryAccess), 32'd0);
        checkOutput("reset ws3 instruction", bus3.instruction_MemoryAccess, 32'd0);
        @(negedge clock);
        resetMachine_n = 1'b1;
        @(posedge clock);
        #1;

        // Zero-wait instance: loads, stores, extension, forwarding, wrap
        doStore(1'b0, 2'b10, 32'h10, 32'h8000_00FF, 32'h101, 1'b0);
        doLoad (1'b0, 2'b00, 1'b0, 32'h10, 32'h102, 32'hFFFF_FFFF, 1'b0);
        doLoad (1'b0, 2'b00, 1'b1, 32'h10, 32'h103, 32'h0000_00FF, 1'b0);
        doLoad (1'b0, 2'b01, 1'b0, 32'h12, 32'h104, 32'hFFFF_8000, 1'b0);
        doLoad (1'b0, 2'b01, 1'b1, 32'h12, 32'h105, 32'h0000_8000, 1'b0);
        doLoad (1'b0, 2'b00, 1'b0, 32'h13, 32'h106, 32'hFFFF_FF80, 1'b0);
        doStore(1'b0, 2'b10, 32'h20, 32'h1122_3344, 32'h107, 1'b0);
        doStore(1'b0, 2'b00, 32'h21, 32'h0000_00AB, 32'h108, 1'b0);
        doLoad (1'b0, 2'b10, 1'b0, 32'h20, 32'h109, 32'h1122_AB44, 1'b0);
        doStore(1'b0, 2'b01, 32'h22, 32'h0000_BEEF, 32'h10A, 1'b0);
        doLoad (1'b0, 2'b10, 1'b0, 32'h20, 32'h10B, 32'hBEEF_AB44, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF,
                      1'b0, 5'd0, 32'h10C, 32'd0, 1'b0, 1'b0, s);
        doLoad (1'b0, 2'b10, 1'b0, 32'h30, 32'h10D, 32'hDEAD_BEEF, 1'b0);
        doLoad (1'b0, 2'b10, 1'b0, 32'h1030, 32'h10E, 32'hDEAD_BEEF, 1'b0);

        // Misaligned and illegal-size accesses
        doLoad (1'b0, 2'b10, 1'b0, 32'h22, 32'h10F, TRAP ? 32'd0 : 32'hBEEF_AB44, TRAP);
        doStore(1'b0, 2'b10, 32'h22, 32'h9999_9999, 32'h110, TRAP);
        doLoad (1'b0, 2'b10, 1'b0, 32'h20, 32'h111, TRAP ? 32'hBEEF_AB44 : 32'h9999_9999, 1'b0);
        doLoad (1'b0, 2'b11, 1'b0, 32'h30, 32'h112, TRAP ? 32'd0 : 32'hDEAD_BEEF, TRAP);

        // Read and write together: write lands, read data is zero
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h34, 32'h0F0F_0F0F, 1'b0, 32'd0,
                      1'b0, 5'd0, 32'h113, 32'd0, 1'b1, 1'b0, s);
        doLoad (1'b0, 2'b10, 1'b0, 32'h34, 32'h114, 32'h0F0F_0F0F, 1'b0);

        // Plain ALU instruction passes through
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b0, 32'd0,
                      1'b1, 5'd7, 32'h115, 32'd0, 1'b0, 1'b0, s);

        // Three-wait instance: stall length, bubbles, latency
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BAD_F00D, 1'b0, 32'd0,
                      1'b0, 5'd0, 32'h301, 32'd0, 1'b0, 1'b0, s);
        checkOutput("ws3 store stall cycles", 32'(s), 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1'b0, 32'd0,
                      1'b1, 5'd9, 32'h302, 32'h0BAD_F00D, 1'b1, 1'b0, s);
        checkOutput("ws3 load stall cycles", 32'(s), 32'd3);

        // Reset pulsed while a store is waiting: outputs clear, memory untouched
        driveBus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h5555_5555, 1'b0, 32'd0, 1'b0, 5'd0, 32'h303);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        checkOutput("ws3 stall in wait", 32'(bus3.stall_MemoryAccess), 32'd1);
        resetMachine_n = 1'b0;
        driveIdle(1'b1);
        #1;
        checkOutput("mid-reset stall", 32'(bus3.stall_MemoryAccess), 32'd0);
        checkOutput("mid-reset instruction", bus3.instruction_MemoryAccess, 32'd0);
        checkOutput("mid-reset readData", bus3.dataReadDataMemory_MemoryAccess, 32'd0);
        checkOutput("mid-reset resultALU", bus3.resultALU_MemoryAccess, 32'd0);
        checkOutput("mid-reset regWrite", 32'(bus3.enableWriteRegisterFile_MemoryAccess), 32'd0);
        checkOutput("mid-reset memRead", 32'(bus3.enableReadDataMemory_MemoryAccess), 32'd0);
        @(negedge clock);
        resetMachine_n = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1'b0, 32'd0,
                      1'b1, 5'd9, 32'h304, 32'h0BAD_F00D, 1'b1, 1'b0, s);
        checkOutput("ws3 post-reset stall cycles", 32'(s), 32'd3);

        repeat (3) @(negedge clock);
        checkOutput("ws0 scoreboard drained", 32'(q0.size()), 32'd0);
        checkOutput("ws3 scoreboard drained", 32'(q3.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
